// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RSP,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small fetch buffer holding instructions with their PCs
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          clear,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Explicit wrap keeps non-power-of-two-sized pointer math out of the picture
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: issues imem requests from the PC and buffers results
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr,
    input  logic        flush,
    output logic        pc_advance,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        fetch_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          fetch_err_q, fetch_err_d;

    logic          issue;
    logic          pc_ok;
    logic          rsp_accept;
    logic          fifo_push, fifo_pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head, push_entry;

    assign pc_ok = is_aligned(pc_addr[1:0]);

    // Issuing only with a free slot guarantees the response always has room
    assign imem_req_valid = !rst && (state_q == IDLE) && !flush && !fetch_err_q
                            && pc_ok && (fifo_count < DEPTH_C);
    assign issue          = imem_req_valid && imem_req_ready;
    assign pc_advance     = issue;
    assign imem_req_addr  = pc_addr;

    assign rsp_accept = (state_q == WAIT_RSP) && imem_rsp_valid && !flush;
    assign fifo_push  = rsp_accept && !fifo_full;
    assign push_entry = '{pc: req_pc_q, instr: imem_rsp_data};

    assign instr_valid = !fifo_empty;
    assign fifo_pop    = instr_valid && instr_ready;
    assign instr_data  = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;
    assign fetch_err   = fetch_err_q;

    always_comb begin
        state_d     = state_q;
        req_pc_d    = req_pc_q;
        fetch_err_d = fetch_err_q;

        if (flush) begin
            fetch_err_d = 1'b0;
        end else if ((state_q == IDLE) && !pc_ok) begin
            fetch_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d  = WAIT_RSP;
                    req_pc_d = pc_addr;
                end
            end
            WAIT_RSP: begin
                // A response coinciding with flush is simply not pushed
                if (imem_rsp_valid) begin
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_pc_q    <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_pc_q    <= req_pc_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(push_entry),
        .pop      (fifo_pop),
        .clear    (flush),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage, directly downstream of the program counter register. Takes the registered PC, issues word requests to instruction memory over a valid/ready interface with variable response latency, and buffers returned instructions with their PCs in a small FIFO for decode. Pulses `pc_advance` to the next-PC logic on each accepted request, and discards buffered and in-flight fetches on `flush` (branch/jump redirect).

## Interface
- `DEPTH`, default 2: fetch buffer entries, ≥1, power of two.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_addr`  in  32  current PC from program counter.
- `flush`  in  1  redirect: discard buffer and in-flight fetch.
- `pc_advance`  out  1  request accepted this cycle; next-PC logic must load pc+4.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  request address, equals `pc_addr`.
- `imem_rsp_valid`  in  1  response data valid, one cycle per accepted request.
- `imem_rsp_data`  in  32  instruction word.
- `instr_valid`  out  1  buffer head valid.
- `instr_ready`  in  1  decode consumes head.
- `instr_data`  out  32  head instruction.
- `instr_pc`  out  32  head PC.
- `fetch_err`  out  1  sticky misaligned-PC error.

## Operation
- States: IDLE, WAIT_RSP, DROP. At most one request outstanding.
- `imem_req_valid` = IDLE & !flush & !fetch_err & `pc_addr[1:0]`==0 & count<DEPTH. Combinational; a flush may withdraw an unaccepted request (memory tolerates this).
- IDLE → WAIT_RSP when `imem_req_valid & imem_req_ready`; request PC latched into `req_pc`; `pc_advance`=1 that cycle only.
- WAIT_RSP, `imem_rsp_valid` & !flush: push {req_pc, data}, → IDLE.
- WAIT_RSP, flush & !`imem_rsp_valid` → DROP. Flush together with rsp: data discarded, → IDLE.
- DROP: wait for `imem_rsp_valid`, discard, → IDLE. Further flushes in DROP keep DROP.
- FIFO: pop on `instr_valid & instr_ready`. Simultaneous push and pop allowed at any count; push never occurs when full (issue rule reserves the slot).
- Flush empties FIFO at the next edge, overriding same-cycle push/pop; `instr_valid`=0 the following cycle.
- Misaligned PC in IDLE (`pc_addr[1:0]`≠0, no flush): `fetch_err` set at next edge and held, no requests issued; cleared only by flush or reset.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.

## Timing
- Reset: state IDLE, FIFO empty, `req_pc`=0, `fetch_err`=0; `instr_valid`, `pc_advance`, `imem_req_valid` read 0 while rst is high.
- Request accepted at cycle T, response at T+k (k≥1): `instr_valid` at T+k+1 (registered FIFO).
- Next request issues at earliest T+k+1; peak throughput one instruction per 2 cycles with k=1.
- `instr_data`/`instr_pc` are direct FIFO head register outputs; no combinational path from `imem_rsp_*` to `instr_*`.
- `imem_req_addr`, `imem_req_valid` and `pc_advance` depend combinationally on `pc_addr`, `flush`, `imem_req_ready`.
- Reset mid-operation: everything returns to its reset value immediately; a late memory response after reset release in IDLE is ignored.

## Structure
- Package `fetch_pkg`: `fetch_state_t` enum (IDLE, WAIT_RSP, DROP), `fetch_entry_t` struct {pc[31:0], instr[31:0]}.
- Sub-module `fetch_fifo`: parameterised DEPTH FIFO of `fetch_entry_t` with push, pop, clear, full, empty, count; asynchronous reset.
- FSM, issue logic, `req_pc` and `fetch_err` live in the top level.

## Test plan
- Reset, pc_addr=0x0, memory k=1, instr_ready=1: req at 0x0, `pc_advance` 1 cycle, `instr_valid` with pc=0x0 two cycles after acceptance; sequence 0x0,0x4,0x8 in order.
- instr_ready=0, DEPTH=2: exactly two fetches complete, then `imem_req_valid`=0 until a pop; a pop frees a slot and the next request issues on the following cycle.
- Flush while WAIT_RSP (k=3): enter DROP, late response discarded, FIFO empty, next request uses new pc_addr=0x100.
- Flush in the same cycle as `imem_rsp_valid` and a pop on a full FIFO: FIFO empty next cycle, state IDLE, no stale entry.
- pc_addr=0x6: no request, `fetch_err`=1 next cycle and held; flush with pc_addr=0x8 clears it and fetching resumes.
- Assert rst while in WAIT_RSP with two buffered entries: all outputs 0, FIFO empty, state IDLE.
